wb_bus_arbiter: RTL



---
 rtl/wb_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/wb_bus_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the arbiter state encoding.
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: the first set request scanning upward from last_i+1, with wrap.
module rr_priority_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [NUM_MASTERS-1:0] winner_o,
  output logic                   valid_o
);

  // The outer loop walks priority order, so the earliest offset claims the win.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    winner_o = '0;
    valid_o  = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!valid_o && req_i[i] && (i == (int'(last_i) + off) % NUM_MASTERS)) begin
          winner_o[i] = 1'b1;
          valid_o     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, grant locked per CYC,
// with a strobe watchdog and a guard against stale slave ACKs.
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [WB_ADDR_W*NUM_MASTERS-1:0] m_addr_i,
  input  logic [WB_DATA_W*NUM_MASTERS-1:0] m_data_i,
  input  logic [WB_SEL_W*NUM_MASTERS-1:0]  m_sel_i,
  output logic [WB_DATA_W-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [WB_ADDR_W-1:0]             s_addr_o,
  output logic [WB_DATA_W-1:0]             s_data_o,
  output logic [WB_SEL_W-1:0]              s_sel_o,
  input  logic [WB_DATA_W-1:0]             s_data_i,
  input  logic                             s_ack_i,
  input  logic                             s_err_i,
  output logic [NUM_MASTERS-1:0]           grant_o,
  output logic                             timeout_o
);

  localparam int               IDX_W    = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic [WB_ADDR_W-1:0]   addr_arr [NUM_MASTERS];
  logic [WB_DATA_W-1:0]   data_arr [NUM_MASTERS];
  logic [WB_SEL_W-1:0]    sel_arr  [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] win_oh;
  logic                   win_valid;
  logic [IDX_W-1:0]       win_idx;
  logic                   g_cyc, slave_resp, stb_fire, wd_expire;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i] = m_addr_i[i*WB_ADDR_W +: WB_ADDR_W];
    assign data_arr[i] = m_data_i[i*WB_DATA_W +: WB_DATA_W];
    assign sel_arr[i]  = m_sel_i[i*WB_SEL_W +: WB_SEL_W];
  end

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req_i   (m_cyc_i),
    .last_i  (last_grant_q),
    .winner_o(win_oh),
    .valid_o (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  // last_grant_q doubles as the granted index while BUSY/DRAIN.
  assign g_cyc      = m_cyc_i[last_grant_q];
  assign slave_resp = s_ack_i | s_err_i;
  assign stb_fire   = (state_q == BUSY) & g_cyc & m_stb_i[last_grant_q];
  assign wd_expire  = stb_fire & ~slave_resp & (cnt_q == CNT_MAX);

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = m_we_i[last_grant_q];
    s_addr_o = addr_arr[last_grant_q];
    s_data_o = data_arr[last_grant_q];
    s_sel_o  = sel_arr[last_grant_q];
    m_ack_o  = '0;
    m_err_o  = '0;
    if (state_q == BUSY) begin
      s_cyc_o               = g_cyc;
      s_stb_o               = m_stb_i[last_grant_q];
      m_ack_o[last_grant_q] = s_ack_i & g_cyc;
      m_err_o[last_grant_q] = (s_err_i & g_cyc) | wd_expire;
    end
    // A reset cycle abandons the transfer: nothing reaches either side.
    if (rst_i) begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_data_o = '0;
      s_sel_o  = '0;
      m_ack_o  = '0;
      m_err_o  = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        // Hold off while the slave still drives a response from the previous owner.
        if (win_valid && !slave_resp) begin
          grant_d      = win_oh;
          last_grant_d = win_idx;
          cnt_d        = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (slave_resp) begin
          cnt_d = '0;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end else if (stb_fire) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!g_cyc) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;
  assign m_data_o  = s_data_i;

endmodule
